// File: rtl/alu_pkg.sv
// Shared types, widths and helpers for the pipelined ALU.
// The opcode encoding is common to the datapath and to any reference model.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  // Counts up by one, sticking at max instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic [31:0] max);
    return (count >= max) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: one operation on signed operands, with an
// overflow / illegal-shift-amount error flag.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_e          op,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]          sum;
  logic [WIDTH-1:0]          diff;
  logic [WIDTH-1:0]          sra;
  logic signed [2*WIDTH-1:0] prod;
  logic [SHW-1:0]            shamt;
  logic                      shift_oob;
  logic                      mul_ovf;

  assign sum       = a + b;
  assign diff      = a - b;
  assign shamt     = b[SHW-1:0];
  assign shift_oob = |b[WIDTH-1:SHW];
  assign sra       = $signed(a) >>> shamt;
  assign prod      = $signed({{WIDTH{a[WIDTH-1]}}, a}) *
                     $signed({{WIDTH{b[WIDTH-1]}}, b});
  // The product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
  assign mul_ovf   = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

  // NOTE: both outputs get a default first so no path through the case infers a latch.
  always_comb begin
    result = '0;
    error  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        error  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        error  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLL: begin
        result = shift_oob ? '0 : (a << shamt);
        error  = shift_oob;
      end
      OP_SRA: begin
        result = shift_oob ? {WIDTH{a[WIDTH-1]}} : sra;
        error  = shift_oob;
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        error  = mul_ovf;
      end
      default: begin
        result = '0;
        error  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage registered ALU: operand capture, then execute and register,
// with valid tracking and a saturating count of erroring results.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           Opcode,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     Result,
  output logic                 Error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << ERR_CNT_W) - 64'd1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  opcode_e          op_q;
  logic             s1_valid;
  logic [WIDTH-1:0] ex_result;
  logic             ex_error;

  // Operands load only on in_valid, so undriven inputs during idle never
  // reach the datapath.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= opcode_e'(Opcode);
      end
    end
  end

  alu_exec #(.WIDTH(WIDTH)) u_exec (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (ex_result),
    .error  (ex_error)
  );

  // Result and Error hold across idle cycles; only valid operations update them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Error     <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Result <= ex_result;
        Error  <= ex_error;
        if (ex_error)
          err_count <= ERR_CNT_W'(sat_inc(32'(err_count), CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, pipeline and reset corner cases,
// and random traffic against a range-checking arithmetic model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  Opcode = '0;

  logic        out_valid,  out_valid2;
  logic [31:0] Result,     Result2;
  logic        Error,      Error2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .ERR_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Opcode(Opcode),
    .out_valid(out_valid), .Result(Result), .Error(Error), .err_count(err_count)
  );

  alu_pipe #(.WIDTH(32), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Opcode(Opcode),
    .out_valid(out_valid2), .Result(Result2), .Error(Error2), .err_count(err_count2)
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } txn_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        err;
  } vec_t;

  // Model state: what the outputs should show now, plus ops still in flight.
  logic        m_vld = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;
  txn_t        p1 = '{1'b0, 32'd0, 32'd0, 3'd0};
  txn_t        p2 = '{1'b0, 32'd0, 32'd0, 3'd0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics via 64-bit arithmetic and range tests.
  task automatic ref_exec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output logic [31:0] r, output logic e);
    longint sa, sb, s;
    longint maxv, minv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxv = 64'sd2147483647;
    minv = -64'sd2147483648;
    r = '0;
    e = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[31:0]; e = (s > maxv) || (s < minv); end
      3'd1: begin s = sa - sb; r = s[31:0]; e = (s > maxv) || (s < minv); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        if (b > 32'd31) begin r = '0; e = 1'b1; end
        else r = a << b[4:0];
      end
      3'd6: begin
        if (b > 32'd31) begin r = (sa < 0) ? 32'hFFFF_FFFF : 32'h0; e = 1'b1; end
        else begin s = sa >>> b[4:0]; r = s[31:0]; end
      end
      default: begin s = sa * sb; r = s[31:0]; e = (s > maxv) || (s < minv); end
    endcase
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_vld));
    check("Result", 64'(Result), 64'(m_res));
    check("Error", 64'(Error), 64'(m_err));
    check("err_count", 64'(err_count), 64'(m_cnt));
    check("sat.out_valid", 64'(out_valid2), 64'(m_vld));
    check("sat.Result", 64'(Result2), 64'(m_res));
    check("sat.err_count", 64'(err_count2), 64'(m_cnt2));
  endtask

  // One clock: at the falling edge, retire the op launched two calls ago into
  // the model, compare, then launch this call's op.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    logic [31:0] r;
    logic        e;
    @(negedge clk);
    m_vld = p2.v;
    if (p2.v) begin
      ref_exec(p2.a, p2.b, p2.op, r, e);
      m_res = r;
      m_err = e;
      if (e) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    check_outputs();
    p2 = p1;
    p1 = '{v, a, b, op};
    in_valid = v;
    A = a;
    B = b;
    Opcode = op;
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_res = '0; m_err = 1'b0; m_cnt = 0; m_cnt2 = 0;
    p1 = '{1'b0, 32'd0, 32'd0, 3'd0};
    p2 = '{1'b0, 32'd0, 32'd0, 3'd0};
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".Result"}, 64'(Result), 64'd0);
    check({tag, ".Error"}, 64'(Error), 64'd0);
    check({tag, ".err_count"}, 64'(err_count), 64'd0);
    check({tag, ".sat.err_count"}, 64'(err_count2), 64'd0);
  endtask

  vec_t vecs[8];
  int   exp_sat[5];

  initial begin
    vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 1'b1};
    vecs[1] = '{32'hFFFF_FFFB, 32'h0000_0003, 3'd0, 32'hFFFF_FFFE, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 3'd7, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFD, 32'h0000_0007, 3'd7, 32'hFFFF_FFEB, 1'b0};
    vecs[5] = '{32'h8000_0001, 32'h0000_0004, 3'd6, 32'hF800_0000, 1'b0};
    vecs[6] = '{32'h0000_0001, 32'h0000_0020, 3'd5, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd4, 32'hFFFF_FFFF, 1'b0};
    exp_sat = '{1, 2, 3, 3, 3};

    // Reset held for three cycles, then idle.
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst = 1'b0;
    repeat (5) cycle(1'b0, '0, '0, '0);

    // Directed vectors, one at a time.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      cycle(1'b0, '0, '0, '0);
      cycle(1'b0, '0, '0, '0);
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d.Result", i), 64'(Result), 64'(vecs[i].res));
      check($sformatf("vec%0d.Error", i), 64'(Error), 64'(vecs[i].err));
    end
    check("vec.err_count", 64'(err_count), 64'd4);

    // Back-to-back through all opcodes, a one-cycle gap, then two more.
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, $urandom, 3'(i));
    cycle(1'b0, '0, '0, '0);
    cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'd7);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd33, 3'd6);
    repeat (3) cycle(1'b0, '0, '0, '0);

    // Reset asserted between edges with ops in flight.
    cycle(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0);
    cycle(1'b1, 32'h1234_5678, 32'd3, 3'd5);
    #7;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("midflight_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) cycle(1'b0, '0, '0, '0);

    // Five overflowing ADDs against the 2-bit counter.
    for (int i = 0; i < 7; i++) begin
      cycle(i < 5, 32'h7FFF_FFFF, 32'd1, 3'd0);
      if (i >= 2) check($sformatf("sat_seq%0d", i - 2), 64'(err_count2), 64'(exp_sat[i - 2]));
    end

    // Random traffic, undriven operands while idle, biased shift amounts.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 'x, 'x, 'x);
      else cycle(1'b1, ra, rb, rop);
    end
    repeat (3) cycle(1'b0, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
